// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: registers the EXE->MEM bus, captures the SRAM read word and extracts loads.
// Optional MEM_LOAD_FWD_EN: forward extracted load data on MEM_result; otherwise expose ms_load_op.
module mem_stage #(
    parameter int ES_BUS_WD = 165,
    parameter int WS_BUS_WD = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    output logic                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 flush,
    output logic [4:0]           MEM_dest,
    output logic [31:0]          MEM_result,
    output logic                 ms_ex,
    output logic                 ms_inst_eret,
`ifdef MEM_LOAD_FWD_EN
    output logic                 ms_inst_mfc0
`else
    output logic                 ms_inst_mfc0,
    output logic                 ms_load_op
`endif
);
    logic                 ms_valid_q, ms_valid_d;
    logic [ES_BUS_WD-1:0] bus_q, bus_d;
    logic                 rdata_held_q, rdata_held_d;
    logic [31:0]          rdata_q, rdata_d;

    logic        ms_ready_go;
    logic        bus_load;
    logic [31:0] data;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    wire [31:0] addr         = bus_q[164:133];
    wire [4:0]  mfc0_rd      = bus_q[132:128];
    wire        ex           = bus_q[127];
    wire [4:0]  exc_code     = bus_q[126:122];
    wire        bd           = bus_q[121];
    wire        eret         = bus_q[120];
    wire [2:0]  sel          = bus_q[119:117];
    wire        mtc0         = bus_q[116];
    wire        mfc0         = bus_q[115];
    wire [31:0] rt_value     = bus_q[114:83];
    wire [11:0] mem_inst     = bus_q[82:71];
    wire        res_from_mem = bus_q[70];
    wire        gr_we        = bus_q[69];
    wire [4:0]  dest         = bus_q[68:64];
    wire [31:0] alu_result   = bus_q[63:32];
    wire [31:0] pc           = bus_q[31:0];
    wire [1:0]  offset       = alu_result[1:0];
    wire        gr_we_eff    = gr_we & ~ex;

    logic unused_bits;
    assign unused_bits = ^{addr, mem_inst[11:8], mem_inst[1]};

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = ~ms_valid_q | (ws_allowin & ms_ready_go);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign bus_load       = es_to_ms_valid & ms_allowin;

    // Once held, the latched word wins over the SRAM, whose output may have moved on.
    assign data = rdata_held_q ? rdata_q : data_sram_rdata;

    always_comb begin
        ms_valid_d   = ms_valid_q;
        bus_d        = bus_q;
        rdata_held_d = rdata_held_q;
        rdata_d      = rdata_q;
        if (flush) begin
            ms_valid_d   = 1'b0;
            bus_d        = '0;
            rdata_held_d = 1'b0;
        end else begin
            if (ms_allowin) ms_valid_d = es_to_ms_valid;
            if (bus_load) begin
                bus_d        = es_to_ms_bus;
                rdata_held_d = 1'b0;
            end else if (ms_valid_q && !rdata_held_q && !ws_allowin) begin
                // Only reachable in the first cycle after a load: the word is valid just once.
                rdata_held_d = 1'b1;
                rdata_d      = data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            rdata_held_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            rdata_held_q <= rdata_held_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        case (offset)
            2'd0:    byte_val = data[7:0];
            2'd1:    byte_val = data[15:8];
            2'd2:    byte_val = data[23:16];
            default: byte_val = data[31:24];
        endcase
        half_val = offset[1] ? data[31:16] : data[15:0];

        extracted = data;
        if (mem_inst[2])      extracted = {{24{byte_val[7]}}, byte_val};
        else if (mem_inst[3]) extracted = {24'd0, byte_val};
        else if (mem_inst[4]) extracted = {{16{half_val[15]}}, half_val};
        else if (mem_inst[5]) extracted = {16'd0, half_val};
        else if (mem_inst[6]) begin
            case (offset)
                2'd0:    extracted = {data[7:0],  rt_value[23:0]};
                2'd1:    extracted = {data[15:0], rt_value[15:0]};
                2'd2:    extracted = {data[23:0], rt_value[7:0]};
                default: extracted = data;
            endcase
        end else if (mem_inst[7]) begin
            case (offset)
                2'd0:    extracted = data;
                2'd1:    extracted = {rt_value[31:24], data[31:8]};
                2'd2:    extracted = {rt_value[31:16], data[31:16]};
                default: extracted = {rt_value[31:8],  data[31:24]};
            endcase
        end
    end

    assign final_result = res_from_mem ? extracted : alu_result;

    assign ms_to_ws_bus = {alu_result, mfc0_rd, ex, exc_code, bd, eret, sel,
                           mtc0, mfc0, gr_we_eff, dest, final_result, pc};

    assign MEM_dest     = (ms_valid_q && gr_we_eff) ? dest : 5'd0;
    assign ms_ex        = ms_valid_q & ex;
    assign ms_inst_eret = ms_valid_q & eret;
    assign ms_inst_mfc0 = ms_valid_q & mfc0;
`ifdef MEM_LOAD_FWD_EN
    assign MEM_result   = final_result;
`else
    assign MEM_result   = alu_result;
    assign ms_load_op   = res_from_mem & ms_valid_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, read-word hold, exceptions, flush, reset.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [164:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [119:0] ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic         flush;
    logic [4:0]   MEM_dest;
    logic [31:0]  MEM_result;
    logic         ms_ex, ms_inst_eret, ms_inst_mfc0;
`ifndef MEM_LOAD_FWD_EN
    logic         ms_load_op;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_rdata(data_sram_rdata), .flush(flush), .MEM_dest(MEM_dest),
        .MEM_result(MEM_result), .ms_ex(ms_ex), .ms_inst_eret(ms_inst_eret),
`ifdef MEM_LOAD_FWD_EN
        .ms_inst_mfc0(ms_inst_mfc0)
`else
        .ms_inst_mfc0(ms_inst_mfc0), .ms_load_op(ms_load_op)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [164:0] mk(input logic [31:0] alu, input logic [11:0] mi,
                                        input logic rfm, input logic we, input logic [4:0] dst,
                                        input logic [31:0] rt, input logic ex, input logic [4:0] exc,
                                        input logic mfc0, input logic eret, input logic [4:0] rd);
        logic [164:0] b;
        b = '0;
        b[164:133] = alu;  b[132:128] = rd;  b[127] = ex;  b[126:122] = exc;
        b[120] = eret;     b[115] = mfc0;    b[114:83] = rt; b[82:71] = mi;
        b[70] = rfm;       b[69] = we;       b[68:64] = dst; b[63:32] = alu;
        b[31:0] = 32'hBFC0_0000 | alu;
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a bus for one edge; afterwards we sit in the first cycle after the load.
    task automatic issue(input logic [164:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        cyc();
        es_to_ms_valid = 1'b0;
        $display("issue bus alu=%h mem_inst=%h", b[63:32], b[82:71]);
    endtask

    task automatic chk_load(input string tag, input logic [31:0] alu, input logic [31:0] exp);
        chk({tag, "_final"}, 120'(ms_to_ws_bus[63:32]), 120'(exp));
`ifdef MEM_LOAD_FWD_EN
        chk({tag, "_memres"}, 120'(MEM_result), 120'(exp));
`else
        chk({tag, "_memres"}, 120'(MEM_result), 120'(alu));
        chk({tag, "_loadop"}, 120'(ms_load_op), 120'(1));
`endif
    endtask

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_rdata = '0; flush = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_valid", 120'(ms_to_ws_valid), 120'(0));
        chk("rst_allowin", 120'(ms_allowin), 120'(1));
        chk("rst_bus", ms_to_ws_bus, 120'(0));
        chk("rst_dest", 120'(MEM_dest), 120'(0));
        chk("rst_result", 120'(MEM_result), 120'(0));

        // lb / lbu at byte offset 3
        issue(mk(32'h1003, 12'h004, 1, 1, 5'd3, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'h80FF7F01; #1;
        chk("lb_valid", 120'(ms_to_ws_valid), 120'(1));
        chk_load("lb", 32'h1003, 32'hFFFFFF80);
        chk("lb_dest", 120'(MEM_dest), 120'(3));
        chk("lb_pc", 120'(ms_to_ws_bus[31:0]), 120'(32'hBFC01003));
        chk("lb_badv", 120'(ms_to_ws_bus[119:88]), 120'(32'h1003));
        issue(mk(32'h1003, 12'h008, 1, 1, 5'd3, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'h80FF7F01; #1;
        chk_load("lbu", 32'h1003, 32'h00000080);

        // lh / lhu upper half, lw
        issue(mk(32'h1006, 12'h010, 1, 1, 5'd4, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'h9ABC1234; #1;
        chk_load("lh", 32'h1006, 32'hFFFF9ABC);
        issue(mk(32'h1006, 12'h020, 1, 1, 5'd4, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'h9ABC1234; #1;
        chk_load("lhu", 32'h1006, 32'h00009ABC);

        // lwl offset 1, lwr offset 2
        issue(mk(32'h2001, 12'h040, 1, 1, 5'd5, 32'h11223344, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'hAABBCCDD; #1;
        chk_load("lwl1", 32'h2001, 32'hCCDD3344);
        issue(mk(32'h2002, 12'h080, 1, 1, 5'd5, 32'h11223344, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'hAABBCCDD; #1;
        chk_load("lwr2", 32'h2002, 32'h1122AABB);

        // ALU op: result bypasses the SRAM
        issue(mk(32'h0000_0055, 12'h000, 0, 1, 5'd6, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        data_sram_rdata = 32'hFFFFFFFF; #1;
        chk("alu_final", 120'(ms_to_ws_bus[63:32]), 120'(32'h55));
        chk("alu_memres", 120'(MEM_result), 120'(32'h55));

        // lw stalled 3 cycles; SRAM word changes after the first cycle
        issue(mk(32'h3000, 12'h001, 1, 1, 5'd7, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        ws_allowin = 1'b0; data_sram_rdata = 32'h12345678; #1;
        chk_load("lw_c1", 32'h3000, 32'h12345678);
        chk("lw_c1_allowin", 120'(ms_allowin), 120'(0));
        cyc(); data_sram_rdata = 32'hDEADBEEF; #1;
        chk_load("lw_c2", 32'h3000, 32'h12345678);
        chk("lw_c2_valid", 120'(ms_to_ws_valid), 120'(1));
        cyc();
        chk_load("lw_c3", 32'h3000, 32'h12345678);
        ws_allowin = 1'b1; #1;
        chk_load("lw_handoff", 32'h3000, 32'h12345678);
        chk("lw_handoff_allowin", 120'(ms_allowin), 120'(1));
        cyc();
        chk("lw_after_valid", 120'(ms_to_ws_valid), 120'(0));

        // exception kills the write; flush next cycle beats a new load
        issue(mk(32'h4000, 12'h000, 0, 1, 5'd8, 32'h0, 1, 5'h05, 0, 0, 5'd0));
        chk("ex_ms_ex", 120'(ms_ex), 120'(1));
        chk("ex_bus_ex", 120'(ms_to_ws_bus[82]), 120'(1));
        chk("ex_code", 120'(ms_to_ws_bus[81:77]), 120'(5));
        chk("ex_gr_we", 120'(ms_to_ws_bus[69]), 120'(0));
        chk("ex_dest", 120'(MEM_dest), 120'(0));
        flush = 1'b1; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(32'h5000, 12'h001, 1, 1, 5'd9, 32'h0, 0, 5'd0, 0, 0, 5'd0);
        cyc();
        flush = 1'b0; es_to_ms_valid = 1'b0;
        chk("flush_valid", 120'(ms_to_ws_valid), 120'(0));
        chk("flush_bus", ms_to_ws_bus, 120'(0));
        chk("flush_ms_ex", 120'(ms_ex), 120'(0));

        // mfc0 visible only while valid; eret
        issue(mk(32'h0, 12'h000, 0, 1, 5'd4, 32'h0, 0, 5'd0, 1, 0, 5'd12));
        chk("mfc0_flag", 120'(ms_inst_mfc0), 120'(1));
        chk("mfc0_rd", 120'(ms_to_ws_bus[87:83]), 120'(12));
        chk("mfc0_dest", 120'(MEM_dest), 120'(4));
        cyc();
        chk("mfc0_gone", 120'(ms_inst_mfc0), 120'(0));
        chk("mfc0_gone_dest", 120'(MEM_dest), 120'(0));
        issue(mk(32'h0, 12'h000, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 1, 5'd0));
        chk("eret_flag", 120'(ms_inst_eret), 120'(1));
        chk("eret_bus", 120'(ms_to_ws_bus[75]), 120'(1));
        cyc();

        // reset in the middle of a held stall
        issue(mk(32'h6000, 12'h001, 1, 1, 5'd10, 32'h0, 0, 5'd0, 0, 0, 5'd0));
        ws_allowin = 1'b0; data_sram_rdata = 32'hCAFEF00D;
        cyc(); data_sram_rdata = 32'h0;
        chk_load("held_pre_rst", 32'h6000, 32'hCAFEF00D);
        reset = 1'b1;
        cyc();
        reset = 1'b0; #1;
        chk("rst2_valid", 120'(ms_to_ws_valid), 120'(0));
        chk("rst2_allowin", 120'(ms_allowin), 120'(1));
        chk("rst2_bus", ms_to_ws_bus, 120'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
